viterbi_ber_checker: RTL and testbench
======================================

# viterbi_ber_checker

Bit-error-rate checker at the output of the Viterbi transmit/receive chain. Keeps a history of source bits that enter the convolutional encoder, and finds the decoder latency on its own. Once it has locked to that latency, it compares every decoded bit against the source bit at that delay and reports bit, error and loss-of-lock statistics. It sits directly downstream of the decoder and taps the encoder input in parallel.

## Interface
- MAX_LAT, 64: number of candidate latencies searched, 0..MAX_LAT-1, measured in source bits.
- LOCK_LEN, 32: consecutive matching comparisons required to declare lock.
- LOSS_WIN, 64: comparisons per loss-detection window while locked.
- LOSS_THR, 8: errors within one window that force loss of lock.
- CW, 32: width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- src_bit_i  in  1  source bit, the same bit presented to the encoder.
- src_valid_i  in  1  src_bit_i is accepted this cycle.
- dec_bit_i  in  1  decoded bit from the decoder.
- dec_valid_i  in  1  dec_bit_i is valid this cycle.
- clear_i  in  1  synchronous clear of the statistics.
- lock_o  out  1  checker is locked.
- lat_o  out  $clog2(MAX_LAT)  candidate latency, or the locked latency.
- bit_ct_o  out  CW  comparisons made while locked.
- err_ct_o  out  CW  mismatches while locked.
- err_o  out  1  one-cycle pulse for each mismatch while locked.
- sat_o  out  1  sticky flag: a counter has saturated.

## Operation
- History register hist[MAX_LAT-1:0]. On src_valid_i it shifts, with src_bit_i entering at hist[0].
  - hist[k] is the source bit accepted k+1 accepts ago.
  - When src_valid_i and dec_valid_i are high in the same cycle, the comparison uses the pre-shift history.
- Fill counter counts source accepts and saturates at MAX_LAT. A comparison at candidate c is qualified only if fill > c. Unqualified samples are ignored and change no state.
- Qualified comparison: mismatch = dec_bit_i ^ hist[lat].
- State SEARCH:
  - A match increments the run counter.
  - A mismatch clears the run counter and advances lat by 1, wrapping from MAX_LAT-1 to 0.
  - When the run counter reaches LOCK_LEN, the state goes to LOCKED and lat holds.
- State LOCKED:
  - Each qualified comparison increments bit_ct. A mismatch also increments err_ct and pulses err_o.
  - The window counter counts comparisons from 0 to LOSS_WIN-1, together with a window error count.
  - When the window error count reaches LOSS_THR, the state goes to SEARCH:
    - lat is set to (lat+1) mod MAX_LAT;
    - the run and window counters are cleared;
    - bit_ct and err_ct hold.
  - At the end of a window, the window error count is cleared.
  - The comparison that reaches LOSS_THR is itself counted in bit_ct and err_ct.
- Counters saturate at all-ones and do not wrap. sat_o sets when either counter saturates and stays set until clear_i or rst.
- clear_i:
  - zeroes bit_ct, err_ct and sat_o;
  - does not affect the state, lat, history or fill counter;
  - takes priority over an increment in the same cycle.
- Source data must be non-periodic with period ≤ MAX_LAT, for example PRBS; constant data can lock to a wrong latency. This is by design.

## Timing
- Reset values:
  - lock_o 0, lat_o 0, bit_ct_o 0, err_ct_o 0, err_o 0, sat_o 0;
  - state SEARCH, history 0, fill 0.
- All outputs are registered.
- lock_o rises in the cycle after the LOCK_LEN-th consecutive match.
- lock_o falls in the cycle after the comparison that reaches LOSS_THR.
- err_o and the counters reflect a comparison one cycle after the cycle with dec_valid_i high.
- Throughput: one comparison per cycle, with no backpressure. Inputs are never stalled.
- rst asserted mid-operation returns the block to the full reset state immediately; no statistics are retained.

## Structure
- Package viterbi_ber_pkg holds:
  - typedef ber_state_t {SEARCH, LOCKED};
  - default localparams for MAX_LAT, LOCK_LEN, LOSS_WIN and LOSS_THR.
- Sub-module ber_sat_counter: CW-bit saturating counter with clear, increment and a saturated output. It is instantiated twice, for bit_ct and err_ct.
- The remaining logic is one module: the history and fill logic, the state machine, and the window logic.

## Test plan
- PRBS-7 source; decoder replaced by a 17-bit delay model; no errors:
  - lock_o=1 and lat_o=16 after the matching run;
  - after 1000 further bits: bit_ct_o=1000, err_ct_o=0.
- Same setup, with decoded bits flipped at 5 isolated positions 100 bits apart:
  - err_ct_o=5, five err_o pulses, lock_o stays 1.
- Same setup, with a burst of 8 flipped bits inside one window:
  - lock_o falls one cycle after the 8th flip;
  - the checker relocks at lat_o=16 after wrap-around;
  - err_ct_o=8.
- CW=4 with 20 locked comparisons:
  - bit_ct_o=15, sat_o=1;
  - clear_i pulse gives bit_ct_o=0, sat_o=0, and lock_o is unchanged.
- src_valid_i and dec_valid_i high together on every cycle, against alternating single-cycle gaps:
  - identical lat_o and counts in both runs.
- rst pulsed while locked:
  - all outputs return to 0 immediately;
  - the checker relocks at the same latency.

Source files
------------

// File: rtl/viterbi_ber_pkg.sv
// Shared types and default sizing for the Viterbi chain BER checker.
package viterbi_ber_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } ber_state_t;

    localparam int unsigned MAX_LAT_DEF  = 64;
    localparam int unsigned LOCK_LEN_DEF = 32;
    localparam int unsigned LOSS_WIN_DEF = 64;
    localparam int unsigned LOSS_THR_DEF = 8;
    localparam int unsigned CW_DEF       = 32;

endpackage

// File: rtl/ber_sat_counter.sv
// Saturating up-counter with synchronous clear; sat_next flags that the
// value being loaded this cycle is all-ones.
module ber_sat_counter #(
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          sat_next
);

    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (clr)
            cnt_next = '0;
        else if (inc && (cnt != '1))
            cnt_next = cnt + CW'(1);
    end

    assign sat_next = (cnt_next == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else
            cnt <= cnt_next;
    end

endmodule

// File: rtl/viterbi_ber_checker.sv
// BER checker: searches the decoder latency against a source-bit history,
// then counts bits/errors while locked and drops lock on an error burst.
module viterbi_ber_checker
    import viterbi_ber_pkg::*;
#(
    parameter int unsigned MAX_LAT  = MAX_LAT_DEF,
    parameter int unsigned LOCK_LEN = LOCK_LEN_DEF,
    parameter int unsigned LOSS_WIN = LOSS_WIN_DEF,
    parameter int unsigned LOSS_THR = LOSS_THR_DEF,
    parameter int unsigned CW       = CW_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       src_bit_i,
    input  logic                       src_valid_i,
    input  logic                       dec_bit_i,
    input  logic                       dec_valid_i,
    input  logic                       clear_i,
    output logic                       lock_o,
    output logic [$clog2(MAX_LAT)-1:0] lat_o,
    output logic [CW-1:0]              bit_ct_o,
    output logic [CW-1:0]              err_ct_o,
    output logic                       err_o,
    output logic                       sat_o
);

    localparam int unsigned LW = $clog2(MAX_LAT);
    localparam int unsigned FW = $clog2(MAX_LAT + 1);
    localparam int unsigned RW = $clog2(LOCK_LEN + 1);
    localparam int unsigned WW = $clog2(LOSS_WIN);
    localparam int unsigned EW = $clog2(LOSS_THR + 1);

    logic [MAX_LAT-1:0] hist;
    logic [FW-1:0]      fill;

    ber_state_t    state, state_n;
    logic [LW-1:0] lat, lat_n, lat_inc;
    logic [RW-1:0] run, run_n;
    logic [WW-1:0] win_cnt, win_cnt_n;
    logic [EW-1:0] win_err, win_err_n;
    logic          lock_r, err_r, err_n, sat_r;
    logic          qual, mis, cmp_locked;
    logic          bit_sat_n, err_sat_n;

    // History is read before the shift, so a same-cycle accept is not seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (src_valid_i) begin
            hist <= {hist[MAX_LAT-2:0], src_bit_i};
            if (fill != FW'(MAX_LAT))
                fill <= fill + FW'(1);
        end
    end

    assign qual    = dec_valid_i && (fill > FW'(lat));
    assign mis     = dec_bit_i ^ hist[lat];
    assign lat_inc = (lat == LW'(MAX_LAT - 1)) ? '0 : lat + LW'(1);

    always_comb begin
        state_n    = state;
        lat_n      = lat;
        run_n      = run;
        win_cnt_n  = win_cnt;
        win_err_n  = win_err;
        cmp_locked = 1'b0;
        err_n      = 1'b0;
        if (qual) begin
            case (state)
                SEARCH: begin
                    if (mis) begin
                        run_n = '0;
                        lat_n = lat_inc;
                    end else if (run == RW'(LOCK_LEN - 1)) begin
                        state_n   = LOCKED;
                        run_n     = '0;
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else begin
                        run_n = run + RW'(1);
                    end
                end
                LOCKED: begin
                    cmp_locked = 1'b1;
                    err_n      = mis;
                    if (mis && (win_err == EW'(LOSS_THR - 1))) begin
                        state_n   = SEARCH;
                        lat_n     = lat_inc;
                        run_n     = '0;
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else if (win_cnt == WW'(LOSS_WIN - 1)) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else begin
                        win_cnt_n = win_cnt + WW'(1);
                        win_err_n = win_err + EW'(mis);
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SEARCH;
            lat     <= '0;
            run     <= '0;
            win_cnt <= '0;
            win_err <= '0;
            lock_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state   <= state_n;
            lat     <= lat_n;
            run     <= run_n;
            win_cnt <= win_cnt_n;
            win_err <= win_err_n;
            lock_r  <= (state_n == LOCKED);
            err_r   <= err_n;
        end
    end

    ber_sat_counter #(.CW(CW)) u_bit_ct (
        .clk      (clk),
        .rst      (rst),
        .clr      (clear_i),
        .inc      (cmp_locked),
        .cnt      (bit_ct_o),
        .sat_next (bit_sat_n)
    );

    ber_sat_counter #(.CW(CW)) u_err_ct (
        .clk      (clk),
        .rst      (rst),
        .clr      (clear_i),
        .inc      (err_n),
        .cnt      (err_ct_o),
        .sat_next (err_sat_n)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sat_r <= 1'b0;
        else if (clear_i)
            sat_r <= 1'b0;
        else if (bit_sat_n || err_sat_n)
            sat_r <= 1'b1;
    end

    assign lock_o = lock_r;
    assign lat_o  = lat;
    assign err_o  = err_r;
    assign sat_o  = sat_r;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Bench for viterbi_ber_checker: PRBS-7 source, 17-bit delay decoder model,
// queue-based reference model; a CW=4 copy shares the stimulus.
module tb_viterbi_ber_checker;

    localparam int MAXL  = 64;
    localparam int LOCKL = 32;
    localparam int WIN   = 64;
    localparam int THR   = 8;
    localparam int DELAY = 17;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic src_bit_i = 1'b0, src_valid_i = 1'b0;
    logic dec_bit_i = 1'b0, dec_valid_i = 1'b0;
    logic clear_i = 1'b0;

    logic        lock_o, err_o, sat_o;
    logic [5:0]  lat_o;
    logic [31:0] bit_ct_o, err_ct_o;
    logic        lock4, err4, sat4;
    logic [5:0]  lat4;
    logic [3:0]  bit4, errc4;

    always #5 clk = ~clk;

    viterbi_ber_checker dut (
        .clk(clk), .rst(rst), .src_bit_i(src_bit_i), .src_valid_i(src_valid_i),
        .dec_bit_i(dec_bit_i), .dec_valid_i(dec_valid_i), .clear_i(clear_i),
        .lock_o(lock_o), .lat_o(lat_o), .bit_ct_o(bit_ct_o), .err_ct_o(err_ct_o),
        .err_o(err_o), .sat_o(sat_o)
    );

    viterbi_ber_checker #(.CW(4)) dut4 (
        .clk(clk), .rst(rst), .src_bit_i(src_bit_i), .src_valid_i(src_valid_i),
        .dec_bit_i(dec_bit_i), .dec_valid_i(dec_valid_i), .clear_i(clear_i),
        .lock_o(lock4), .lat_o(lat4), .bit_ct_o(bit4), .err_ct_o(errc4),
        .err_o(err4), .sat_o(sat4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: every accepted source bit kept in order.
    bit     srcq[$];
    int     m_lat, m_run, m_wpos, m_werr;
    bit     m_locked, m_err;
    longint m_bits, m_errs;
    logic [6:0] prbs;

    function automatic void model_reset();
        srcq.delete();
        m_lat = 0; m_run = 0; m_wpos = 0; m_werr = 0;
        m_locked = 0; m_err = 0; m_bits = 0; m_errs = 0;
    endfunction

    function automatic void model_step(bit sv, bit sb, bit dv, bit db, bit clr);
        int n, fill;
        bit mis;
        m_err = 0;
        n = srcq.size();
        fill = (n < MAXL) ? n : MAXL;
        if (dv && fill > m_lat) begin
            mis = (db != srcq[n - 1 - m_lat]);
            if (!m_locked) begin
                if (mis) begin
                    m_run = 0;
                    m_lat = (m_lat + 1) % MAXL;
                end else begin
                    m_run++;
                    if (m_run == LOCKL) begin
                        m_locked = 1; m_run = 0; m_wpos = 0; m_werr = 0;
                    end
                end
            end else begin
                m_bits++;
                if (mis) begin m_errs++; m_err = 1; m_werr++; end
                m_wpos++;
                if (m_werr == THR) begin
                    m_locked = 0; m_lat = (m_lat + 1) % MAXL;
                    m_run = 0; m_wpos = 0; m_werr = 0;
                end else if (m_wpos == WIN) begin
                    m_wpos = 0; m_werr = 0;
                end
            end
        end
        if (clr) begin m_bits = 0; m_errs = 0; end
        if (sv) srcq.push_back(sb);
    endfunction

    function automatic logic [31:0] clip(longint v, longint lim);
        return (v > lim) ? 32'(lim) : 32'(v);
    endfunction

    task automatic compare_all();
        check("lock", lock_o, m_locked);
        check("lat", lat_o, m_lat);
        check("bit_ct", bit_ct_o, clip(m_bits, 64'hFFFF_FFFF));
        check("err_ct", err_ct_o, clip(m_errs, 64'hFFFF_FFFF));
        check("err_o", err_o, m_err);
        check("sat", sat_o, m_bits >= 64'hFFFF_FFFF);
        check("cw4_lock", lock4, m_locked);
        check("cw4_lat", lat4, m_lat);
        check("cw4_bit_ct", bit4, clip(m_bits, 15));
        check("cw4_err_ct", errc4, clip(m_errs, 15));
        check("cw4_err_o", err4, m_err);
        check("cw4_sat", sat4, m_bits >= 15);
    endtask

    task automatic cycle(input bit sv, input bit flip, input bit clr);
        bit sb, db;
        int n;
        n  = srcq.size();
        sb = prbs[6] ^ prbs[5];
        db = ((n >= DELAY) ? srcq[n - DELAY] : 1'b0) ^ flip;
        src_bit_i = sb; src_valid_i = sv;
        dec_bit_i = db; dec_valid_i = sv;
        clear_i = clr;
        @(posedge clk); #1;
        if (sv) prbs = {prbs[5:0], sb};
        model_step(sv, sb, sv, db, clr);
        compare_all();
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst_lock", lock_o, 0);
        check("rst_lat", lat_o, 0);
        check("rst_bit_ct", bit_ct_o, 0);
        check("rst_err_ct", err_ct_o, 0);
        check("rst_err_o", err_o, 0);
        check("rst_sat", sat_o, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    int pulses, accepts;
    bit lock_dropped, sv;
    logic [6:0] seed;
    int ref_lat;
    longint ref_bits, ref_errs;

    initial begin
        prbs = 7'($urandom_range(1, 127));
        do_reset();

        // Acquisition and clean run
        for (int i = 0; i < 400 && !m_locked; i++) cycle(1, 0, 0);
        check("acq_lock", lock_o, 1);
        check("acq_lat", lat_o, 16);
        for (int i = 0; i < 1000; i++) cycle(1, 0, 0);
        check("clean_bits", bit_ct_o, 1000);
        check("clean_errs", err_ct_o, 0);
        check("cw4_bits_sat", bit4, 15);
        check("cw4_sat_set", sat4, 1);

        // Clear wins over a same-cycle increment
        cycle(1, 0, 1);
        check("clr_bits", bit_ct_o, 0);
        check("clr_cw4_bits", bit4, 0);
        check("clr_cw4_sat", sat4, 0);
        check("clr_lock", lock_o, 1);
        for (int i = 0; i < 20; i++) cycle(1, 0, 0);
        check("cw4_20_bits", bit4, 15);
        check("cw4_20_sat", sat4, 1);

        // Isolated errors
        cycle(1, 0, 1);
        pulses = 0; lock_dropped = 0;
        for (int i = 0; i < 500; i++) begin
            cycle(1, (i % 100) == 50, 0);
            if (err_o) pulses++;
            if (!lock_o) lock_dropped = 1;
        end
        check("iso_pulses", pulses, 5);
        check("iso_errs", err_ct_o, 5);
        check("iso_bits", bit_ct_o, 500);
        check("iso_lock_held", lock_dropped, 0);

        // Burst of THR errors inside one window
        cycle(1, 0, 1);
        for (int i = 0; i < WIN && m_wpos != 0; i++) cycle(1, 0, 0);
        for (int i = 0; i < THR; i++) begin
            cycle(1, 1, 0);
            if (i == THR - 2) check("burst_7_lock", lock_o, 1);
        end
        check("burst_drop", lock_o, 0);
        check("burst_errs", err_ct_o, 8);
        for (int i = 0; i < 3000 && !m_locked; i++) cycle(1, 0, 0);
        check("relock", lock_o, 1);
        check("relock_lat", lat_o, 16);
        check("relock_errs", err_ct_o, 8);

        // Same source sequence with dense, alternating and random gaps
        seed = 7'($urandom_range(1, 127));
        for (int r = 0; r < 3; r++) begin
            prbs = seed;
            do_reset();
            accepts = 0;
            for (int c = 0; c < 4000 && accepts < 800; c++) begin
                sv = (r == 0) ? 1'b1 : (r == 1) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
                cycle(sv, 0, 0);
                if (sv) accepts++;
            end
            if (r == 0) begin
                ref_lat = m_lat; ref_bits = m_bits; ref_errs = m_errs;
                check("dense_lock", lock_o, 1);
                check("dense_lat", lat_o, 16);
            end else begin
                check("gap_lat", lat_o, ref_lat);
                check("gap_bits", bit_ct_o, 32'(ref_bits));
                check("gap_errs", err_ct_o, 32'(ref_errs));
            end
        end

        // Asynchronous reset while locked
        check("pre_rst_lock", lock_o, 1);
        do_reset();
        for (int i = 0; i < 400 && !m_locked; i++) cycle(1, 0, 0);
        check("rst_relock", lock_o, 1);
        check("rst_relock_lat", lat_o, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
